// File: rtl/alu_commit_arbiter.sv
// Round-robin commit arbiter: picks one pending ALU result per cycle, acknowledges the unit
// and registers the result into a valid/ready writeback stage.
package core_config_pkg;
  parameter int XLEN       = 32;
  parameter int REG_ADDR_W = 5;
endpackage

module alu_commit_arbiter #(
  parameter int N_UNITS    = 4,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_UNITS-1:0]            i_u_req,
  input  logic [N_UNITS*XLEN-1:0]       i_u_res,
  input  logic [N_UNITS*REG_ADDR_W-1:0] i_u_rd,
  input  logic [N_UNITS-1:0]            i_u_error,
  output logic [N_UNITS-1:0]            o_u_clear,
  input  logic                          i_flush,
  output logic                          o_wb_valid,
  output logic [XLEN-1:0]               o_wb_data,
  output logic [REG_ADDR_W-1:0]         o_wb_rd,
  output logic                          o_wb_error,
  input  logic                          i_wb_ready
);

  localparam int PTR_W = $clog2(N_UNITS);

  logic [PTR_W-1:0]      r_ptr;
  logic                  r_wb_valid;
  logic [XLEN-1:0]       r_wb_data;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_error;

  logic                  w_load_en;
  logic                  w_found;
  logic                  w_grant;
  logic [PTR_W-1:0]      w_gnt;
  logic [XLEN-1:0]       w_gnt_res;
  logic [REG_ADDR_W-1:0] w_gnt_rd;
  logic                  w_gnt_err;
  logic                  w_discard;

  assign w_load_en = !r_wb_valid || i_wb_ready;

  // Scan from the pointer upward with wraparound; first pending unit wins.
  always_comb begin
    int idx;
    idx       = 0;
    w_found   = 1'b0;
    w_gnt     = '0;
    w_gnt_res = '0;
    w_gnt_rd  = '0;
    w_gnt_err = 1'b0;
    for (int i = 0; i < N_UNITS; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_UNITS) idx = idx - N_UNITS;
      if (!w_found && i_u_req[idx]) begin
        w_found   = 1'b1;
        w_gnt     = PTR_W'(idx);
        w_gnt_res = i_u_res[idx*XLEN +: XLEN];
        w_gnt_rd  = i_u_rd[idx*REG_ADDR_W +: REG_ADDR_W];
        w_gnt_err = i_u_error[idx];
      end
    end
  end

  assign w_grant   = !i_rst && w_load_en && !i_flush && w_found;
  // Error-free writes to x0 are acknowledged but never reach the register file.
  assign w_discard = (w_gnt_rd == '0) && !w_gnt_err;

  always_comb begin
    o_u_clear = '0;
    if (i_rst)        o_u_clear = '0;
    else if (i_flush) o_u_clear = i_u_req;
    else if (w_grant) o_u_clear = N_UNITS'(1) << w_gnt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
      r_wb_error <= 1'b0;
    end else if (i_flush) begin
      r_wb_valid <= 1'b0;
    end else if (w_grant) begin
      r_ptr      <= (w_gnt == PTR_W'(N_UNITS-1)) ? '0 : w_gnt + 1'b1;
      r_wb_valid <= !w_discard;
      r_wb_data  <= w_gnt_res;
      r_wb_rd    <= w_gnt_rd;
      r_wb_error <= w_gnt_err;
    end else if (r_wb_valid && i_wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign o_wb_valid = r_wb_valid;
  assign o_wb_data  = r_wb_data;
  assign o_wb_rd    = r_wb_rd;
  assign o_wb_error = r_wb_error;

endmodule

// File: tb/tb_alu_commit_arbiter.sv
// Directed bench for alu_commit_arbiter: reset, round-robin, backpressure, x0 discard,
// flush and pointer wrap with hand-computed expectations.
module tb_alu_commit_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int RW = 5;

  logic            clk;
  logic            rst;
  logic [N-1:0]    u_req;
  logic [N*XL-1:0] u_res;
  logic [N*RW-1:0] u_rd;
  logic [N-1:0]    u_error;
  logic [N-1:0]    u_clear;
  logic            flush;
  logic            wb_valid;
  logic [XL-1:0]   wb_data;
  logic [RW-1:0]   wb_rd;
  logic            wb_error;
  logic            wb_ready;

  int n_checks = 0;
  int n_fail   = 0;

  alu_commit_arbiter #(.N_UNITS(N), .XLEN(XL), .REG_ADDR_W(RW)) dut (
    .i_clk(clk), .i_rst(rst), .i_u_req(u_req), .i_u_res(u_res), .i_u_rd(u_rd),
    .i_u_error(u_error), .o_u_clear(u_clear), .i_flush(flush), .o_wb_valid(wb_valid),
    .o_wb_data(wb_data), .o_wb_rd(wb_rd), .o_wb_error(wb_error), .i_wb_ready(wb_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_unit(input int u, input logic [XL-1:0] res, input logic [RW-1:0] rd,
                          input logic err);
    u_res[u*XL +: XL] = res;
    u_rd[u*RW +: RW]  = rd;
    u_error[u]        = err;
  endtask

  // Inputs change 1 time unit after a rising edge; combinational outputs settle by +2.
  task automatic drive(input logic [N-1:0] req, input logic fl, input logic rdy);
    u_req    = req;
    flush    = fl;
    wb_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [XL-1:0] d,
                          input logic [RW-1:0] rd, input logic e);
    check({tag, "_valid"}, 64'(wb_valid), 64'(v));
    if (v) begin
      check({tag, "_data"}, 64'(wb_data), 64'(d));
      check({tag, "_rd"}, 64'(wb_rd), 64'(rd));
      check({tag, "_err"}, 64'(wb_error), 64'(e));
    end
  endtask

  initial begin
    logic [N-1:0] exp_clr;
    rst = 1'b1; u_req = '0; u_res = '0; u_rd = '0; u_error = '0; flush = 1'b0; wb_ready = 1'b1;
    for (int u = 0; u < N; u++) set_unit(u, 32'h100 + u, RW'(u + 1), 1'b0);
    tick();

    // Reset held two cycles with every unit requesting.
    for (int c = 0; c < 2; c++) begin
      drive(4'b1111, 1'b0, 1'b1);
      check("rst_clear", 64'(u_clear), 64'h0);
      tick();
      check("rst_valid", 64'(wb_valid), 64'h0);
      check("rst_data", 64'(wb_data), 64'h0);
      check("rst_rd", 64'(wb_rd), 64'h0);
    end
    rst = 1'b0;

    // Round-robin: grants 0,1,2,3,0 with rd 1,2,3,4,1.
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b0, 1'b1);
      exp_clr = 4'b0001 << (k % 4);
      check($sformatf("rr_clear%0d", k), 64'(u_clear), 64'(exp_clr));
      tick();
      check_wb($sformatf("rr%0d", k), 1'b1, 32'h100 + 32'(k % 4), RW'((k % 4) + 1), 1'b0);
    end

    // Reset mid-transfer: entry dropped, no acknowledge, pointer back to 0.
    rst = 1'b1;
    drive(4'b1111, 1'b0, 1'b0);
    check("rstmid_clear", 64'(u_clear), 64'h0);
    tick();
    check("rstmid_valid", 64'(wb_valid), 64'h0);
    rst = 1'b0;

    // Backpressure.
    set_unit(2, 32'hDEADBEEF, 5'd7, 1'b0);
    set_unit(3, 32'h12345678, 5'd9, 1'b0);
    drive(4'b0100, 1'b0, 1'b1);
    check("bp_clear_u2", 64'(u_clear), 64'b0100);
    tick();
    check_wb("bp_cap", 1'b1, 32'hDEADBEEF, 5'd7, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(4'b1000, 1'b0, 1'b0);
      check($sformatf("bp_clear_hold%0d", c), 64'(u_clear), 64'h0);
      tick();
      check_wb($sformatf("bp_hold%0d", c), 1'b1, 32'hDEADBEEF, 5'd7, 1'b0);
    end
    drive(4'b1000, 1'b0, 1'b1);
    check("bp_clear_u3", 64'(u_clear), 64'b1000);
    tick();
    check_wb("bp_u3", 1'b1, 32'h12345678, 5'd9, 1'b0);

    // x0 discard (ptr now 0): unit 1 rd=0 err=0.
    set_unit(1, 32'h55, 5'd0, 1'b0);
    drive(4'b0010, 1'b0, 1'b1);
    check("x0_clear", 64'(u_clear), 64'b0010);
    tick();
    check("x0_valid", 64'(wb_valid), 64'h0);
    set_unit(2, 32'hA5, 5'd5, 1'b0);
    drive(4'b0110, 1'b0, 1'b1);
    check("x0_next_u2", 64'(u_clear), 64'b0100);
    tick();
    check_wb("x0_next", 1'b1, 32'hA5, 5'd5, 1'b0);
    set_unit(1, 32'hBAD, 5'd0, 1'b1);
    drive(4'b0010, 1'b0, 1'b1);
    check("x0err_clear", 64'(u_clear), 64'b0010);
    tick();
    check_wb("x0err", 1'b1, 32'hBAD, 5'd0, 1'b1);

    // Hold without grant and without transfer, then drain. ptr is 2.
    drive(4'b0000, 1'b0, 1'b0);
    check("idle_clear", 64'(u_clear), 64'h0);
    tick();
    check_wb("idle_hold", 1'b1, 32'hBAD, 5'd0, 1'b1);

    // Flush with valid entry and units 0, 3 pending.
    drive(4'b1001, 1'b1, 1'b0);
    check("flush_clear", 64'(u_clear), 64'b1001);
    tick();
    check("flush_valid", 64'(wb_valid), 64'h0);
    set_unit(0, 32'h0F0F, 5'd11, 1'b0);
    set_unit(3, 32'h3333, 5'd13, 1'b0);
    drive(4'b1001, 1'b0, 1'b1);
    check("flush_ptr_kept", 64'(u_clear), 64'b1000);
    tick();
    check_wb("flush_after", 1'b1, 32'h3333, 5'd13, 1'b0);

    // Drain with no grant: transfer clears valid.
    drive(4'b0000, 1'b0, 1'b1);
    tick();
    check("drain_valid", 64'(wb_valid), 64'h0);

    // Pointer wrap: reach ptr=3 via unit 2, then only unit 1 requests.
    set_unit(2, 32'h22, 5'd2, 1'b0);
    set_unit(1, 32'h11, 5'd1, 1'b0);
    drive(4'b0100, 1'b0, 1'b1);
    check("wrap_to3", 64'(u_clear), 64'b0100);
    tick();
    drive(4'b0010, 1'b0, 1'b1);
    check("wrap_u1", 64'(u_clear), 64'b0010);
    tick();
    check_wb("wrap_u1", 1'b1, 32'h11, 5'd1, 1'b0);
    drive(4'b1110, 1'b0, 1'b1);
    check("wrap_ptr2", 64'(u_clear), 64'b0100);
    tick();
    check_wb("wrap_ptr2", 1'b1, 32'h22, 5'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_commit_arbiter.md
# alu_commit_arbiter

Round-robin commit arbiter sharing one register-file writeback port between N ALU instances. Each ALU holds its result with `req` high until it sees `clear`; this block picks one requester per cycle, pulses that unit's `clear`, and captures its result into a registered writeback stage with a valid/ready handshake toward the commit/register-file logic. It sits between the ALU commiter interfaces and the writeback stage of the core.

## Interface
- `N_UNITS`, 4, number of ALU commiter interfaces arbitrated (2..8).
- `XLEN`, `core_config_pkg::XLEN`, datapath width.
- `REG_ADDR_W`, `core_config_pkg::REG_ADDR_W`, destination register address width.

- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `u_req`  in  N_UNITS  per-unit result-pending request (ALU `req`).
- `u_res`  in  N_UNITS*XLEN  per-unit result; unit u at `[u*XLEN +: XLEN]`.
- `u_rd`  in  N_UNITS*REG_ADDR_W  per-unit destination register; unit u at `[u*REG_ADDR_W +: REG_ADDR_W]`.
- `u_error`  in  N_UNITS  per-unit error flag (ALU `o_error`).
- `u_clear`  out  N_UNITS  one-hot (or all-requesters on flush) acknowledge; ALU drops `req` next cycle.
- `flush`  in  1  pipeline flush: discard held and pending results.
- `wb_valid`  out  1  writeback entry valid.
- `wb_data`  out  XLEN  writeback data.
- `wb_rd`  out  REG_ADDR_W  writeback destination.
- `wb_error`  out  1  writeback entry carries an error.
- `wb_ready`  in  1  consumer accepts entry this cycle.

## Operation
- State: output register {wb_valid, wb_data, wb_rd, wb_error}; round-robin pointer `ptr` (clog2(N_UNITS) bits).
- `load_en = !wb_valid | wb_ready`. Transfer occurs on `wb_valid & wb_ready`.
- Grant: if `load_en & !flush & |u_req`, grant g = first set bit of `u_req` scanning from `ptr` upward, wrapping N_UNITS-1 -> 0. Otherwise no grant.
- On grant (combinational, same cycle): `u_clear = 1 << g`. Next edge: `ptr <= (g+1) mod N_UNITS`.
- Capture on grant: wb_data/wb_rd/wb_error <= unit g fields; wb_valid <= 1, except x0 discard: if `u_rd[g] == 0` and `u_error[g] == 0`, the grant still clears the unit and advances `ptr` but wb_valid <= 0 (data fields don't-care).
- No grant and transfer: wb_valid <= 0. No grant, no transfer: output register holds all fields unchanged.
- `flush` (priority over grant): `u_clear = u_req` (every pending unit dropped), wb_valid <= 0 next edge, `ptr` unchanged. A transfer coincident with flush is still consumed by the sink.
- Fairness: a continuously requesting unit is granted within N_UNITS grant cycles.
- `ptr` advances only on a grant.

## Timing
- Reset (`rst` high at edge): wb_valid=0, wb_data=0, wb_rd=0, wb_error=0, ptr=0. While `rst` high, `u_clear`=0 regardless of inputs.
- Latency: `u_req` high at cycle t with `load_en` -> `u_clear` in t, `wb_valid` high from t+1.
- Throughput: one commit per cycle while `wb_ready`=1 and requests pending.
- Backpressure: `wb_valid`=1, `wb_ready`=0 -> no grant, `u_clear`=0, wb_* stable until accepted.
- `u_req` deasserted by a unit without `u_clear` is legal; the unit is simply not eligible.
- `rst` mid-transfer: entry discarded, no `u_clear`; units keep `req` and are served after reset from unit 0.

## Test plan
- Reset: hold `rst` 2 cycles with all `u_req`=1 -> `u_clear`=0, wb_valid=0, wb_data=0; first cycle after, unit 0 granted (`u_clear`=4'b0001).
- Round-robin: all 4 units request continuously, `wb_ready`=1, rd=1..4 -> grants 0,1,2,3,0 on consecutive cycles, wb_rd sequence 1,2,3,4,1 starting t+1.
- Backpressure: unit 2 result 0xDEADBEEF rd=7 captured, `wb_ready`=0 for 3 cycles with unit 3 requesting -> wb_* hold 0xDEADBEEF/7, `u_clear`=0; `wb_ready`=1 -> unit 3 cleared same cycle, its result appears next cycle.
- x0 discard: unit 1 rd=0, error=0 -> `u_clear[1]` pulses, wb_valid stays 0, next grant starts from unit 2; same with error=1 -> wb_valid=1, wb_error=1, wb_rd=0.
- Flush: wb_valid=1, units 0 and 3 requesting, `flush`=1 -> `u_clear`=4'b1001, wb_valid=0 next cycle, `ptr` unchanged.
- Pointer wrap: ptr=3, only unit 1 requesting -> grant unit 1, ptr becomes 2.
